// File: rtl/bht_update_sched.sv
// bht_update_sched: arbitrates frontend lookups, queued resolved-branch updates and the
// init walk onto a single-port SRAM of 2-bit saturating counters.
module bht_update_sched #(
    parameter int NR_ENTRIES = 1024,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W = $clog2(NR_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_bp_i,
    input  logic             lookup_valid_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_ready_o,
    output logic             lookup_rvalid_o,
    output logic [1:0]       lookup_cnt_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic             init_busy_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [IDX_W-1:0] mem_addr_o,
    output logic [1:0]       mem_wdata_o,
    input  logic [1:0]       mem_rdata_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;
    state_t r_state, w_next;
    logic [IDX_W-1:0] r_walk;
    logic [IDX_W:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd, r_wr;
    logic [PW:0] r_cnt, w_cnt_nxt;
    logic r_rvalid;
    logic w_push, w_pop, w_req, w_we, w_lk, w_head_tkn;
    logic [IDX_W-1:0] w_addr, w_head_idx;
    logic [1:0] w_wdata, w_sat;

    assign {w_head_tkn, w_head_idx} = r_fifo[r_rd];
    assign w_sat = w_head_tkn ? (mem_rdata_i == 2'd3 ? 2'd3 : mem_rdata_i + 2'd1)
                              : (mem_rdata_i == 2'd0 ? 2'd0 : mem_rdata_i - 2'd1);
    assign init_busy_o = r_state == INIT;
    // Registered fullness: a full FIFO never pushes and pops in the same cycle.
    assign upd_ready_o = !init_busy_o && !flush_bp_i && r_cnt != (PW+1)'(FIFO_DEPTH);
    assign w_push = upd_valid_i && upd_ready_o;
    assign w_pop = r_state == UPD_WR && !flush_bp_i;
    assign w_cnt_nxt = r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    assign w_lk = lookup_valid_i && (r_state == IDLE || r_state == UPD_RD);
    assign lookup_ready_o = w_lk;

    always_comb begin
        w_next = r_state;
        w_req = 1'b0;
        w_we = 1'b0;
        w_addr = '0;
        w_wdata = 2'b00;
        case (r_state)
            INIT: begin
                w_req = 1'b1;
                w_we = 1'b1;
                w_addr = r_walk;
                w_wdata = 2'b01;
                w_next = r_walk == IDX_W'(NR_ENTRIES - 1) ? IDLE : INIT;
            end
            IDLE: begin
                w_req = w_lk;
                w_addr = w_lk ? lookup_idx_i : '0;
                w_next = !w_lk && r_cnt != '0 ? UPD_RD : IDLE;
            end
            UPD_RD: begin
                w_req = 1'b1;
                w_addr = w_lk ? lookup_idx_i : w_head_idx;
                w_next = w_lk ? UPD_RD : UPD_WR;
            end
            UPD_WR: begin
                w_req = !flush_bp_i;
                w_we = !flush_bp_i;
                w_addr = w_head_idx;
                w_wdata = w_sat;
                w_next = w_cnt_nxt != '0 ? UPD_RD : IDLE;
            end
        endcase
        if (flush_bp_i) w_next = INIT;
    end

    // The SRAM port stays quiet while reset is held even though the state is INIT.
    assign mem_req_o = rst_ni && w_req;
    assign mem_we_o = rst_ni && w_we;
    assign mem_addr_o = rst_ni ? w_addr : '0;
    assign mem_wdata_o = rst_ni ? w_wdata : 2'b00;
    assign lookup_rvalid_o = r_rvalid;
    assign lookup_cnt_o = r_rvalid ? mem_rdata_i : 2'b00;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= INIT;
            r_walk <= '0;
            r_rd <= '0;
            r_wr <= '0;
            r_cnt <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rvalid <= w_lk;
            r_walk <= (flush_bp_i || r_state != INIT) ? '0 : r_walk + 1'b1;
            if (flush_bp_i) begin
                r_rd <= '0;
                r_wr <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop) r_rd <= r_rd + 1'b1;
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr] <= {upd_taken_i, upd_idx_i};
    end
endmodule

// File: tb/tb_bht_update_sched.sv
// tb_bht_update_sched: directed stimulus with an abstract counter-table model and
// an SRAM model attached to the DUT memory port.
module tb_bht_update_sched;
    logic clk = 1'b0, rst_n = 1'b0;
    logic flush_bp_i = 0, lookup_valid_i = 0, upd_valid_i = 0, upd_taken_i = 0;
    logic [3:0] lookup_idx_i = 0, upd_idx_i = 0;
    logic lookup_ready_o, lookup_rvalid_o, upd_ready_o, init_busy_o, mem_req_o, mem_we_o;
    logic [1:0] lookup_cnt_o, mem_wdata_o, mem_rdata_i = 2'b00;
    logic [3:0] mem_addr_o;
    logic [1:0] sram [16];

    typedef struct {int idx; bit t;} upd_t;
    upd_t q[$];
    upd_t e;
    int exp_bht [16];
    int init_cnt = 0, prev_exp = 0, v;
    bit prev_acc = 0;
    int n_pass = 0, n_total = 0;

    bht_update_sched #(.NR_ENTRIES(16), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_bp_i(flush_bp_i),
        .lookup_valid_i(lookup_valid_i), .lookup_idx_i(lookup_idx_i),
        .lookup_ready_o(lookup_ready_o), .lookup_rvalid_o(lookup_rvalid_o),
        .lookup_cnt_o(lookup_cnt_o), .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i),
        .upd_taken_i(upd_taken_i), .upd_ready_o(upd_ready_o), .init_busy_o(init_busy_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
            else mem_rdata_i <= sram[mem_addr_o];
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Abstract model: counter table, pending-update queue, init progress.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            init_cnt = 0;
            prev_acc = 0;
            prev_exp = 0;
        end else begin
            chk("rvalid", lookup_rvalid_o, prev_acc);
            chk("lk_cnt", lookup_cnt_o, prev_acc ? prev_exp : 0);
            chk("busy", init_busy_o, init_cnt < 16);
            chk("upd_rdy", upd_ready_o, init_cnt >= 16 && !flush_bp_i && q.size() < 4);
            if (lookup_valid_i && init_cnt >= 16 && !mem_we_o) chk("lk_rdy", lookup_ready_o, 1);
            if (lookup_valid_i && (init_cnt < 16 || mem_we_o)) chk("lk_blk", lookup_ready_o, 0);
            if (lookup_ready_o) begin
                chk("lk_req", mem_req_o, 1);
                chk("lk_we", mem_we_o, 0);
                chk("lk_addr", mem_addr_o, lookup_idx_i);
            end
            if (init_cnt < 16) begin
                chk("init_we", mem_we_o && mem_req_o, 1);
                chk("init_addr", mem_addr_o, init_cnt);
                chk("init_wd", mem_wdata_o, 1);
                exp_bht[init_cnt] = 1;
            end else if (mem_we_o) begin
                chk("wr_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    v = exp_bht[e.idx];
                    v = e.t ? (v < 3 ? v + 1 : 3) : (v > 0 ? v - 1 : 0);
                    chk("wr_addr", mem_addr_o, e.idx);
                    chk("wr_data", mem_wdata_o, v);
                    exp_bht[e.idx] = v;
                end
            end
            if (flush_bp_i && init_cnt >= 16) chk("flush_nowr", mem_we_o, 0);
            prev_acc = lookup_valid_i && lookup_ready_o;
            prev_exp = exp_bht[lookup_idx_i];
            if (upd_valid_i && upd_ready_o) q.push_back('{int'(upd_idx_i), upd_taken_i});
            if (flush_bp_i) begin
                q.delete();
                init_cnt = 0;
            end else if (init_cnt < 16) init_cnt++;
        end
    end

    task automatic upd(input int idx, input bit t);
        int n = 0;
        upd_valid_i = 1;
        upd_idx_i = 4'(idx);
        upd_taken_i = t;
        while (!upd_ready_o && n < 50) begin
            cyc(1);
            n++;
        end
        if (!upd_ready_o) chk("upd_timeout", n, 0);
        else cyc(1);
        upd_valid_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("drain_left", q.size(), 0);
        cyc(1);
    endtask

    task automatic lk(input int idx, input int exp, input string nm);
        int n = 0;
        lookup_valid_i = 1;
        lookup_idx_i = 4'(idx);
        #1;
        while (!lookup_ready_o && n < 50) begin
            cyc(1);
            #1;
            n++;
        end
        if (!lookup_ready_o) chk({nm, "_timeout"}, n, 0);
        else begin
            @(posedge clk);
            #1;
            lookup_valid_i = 0;
            chk({nm, "_rv"}, lookup_rvalid_o, 1);
            chk(nm, lookup_cnt_o, exp);
        end
        lookup_valid_i = 0;
    endtask

    task automatic wait_wr();
        int n = 0;
        while (!(mem_we_o && !init_busy_o) && n < 30) begin
            cyc(1);
            n++;
        end
        chk("upd_wr_seen", mem_we_o && !init_busy_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("rst_rvalid", lookup_rvalid_o, 0);
        chk("rst_cnt", lookup_cnt_o, 0);
        chk("rst_lkrdy", lookup_ready_o, 0);
        chk("rst_updrdy", upd_ready_o, 0);
        chk("rst_busy", init_busy_o, 1);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wd", mem_wdata_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("first_we", mem_we_o, 1);
        chk("first_addr", mem_addr_o, 0);
        cyc(15);
        chk("busy_15", init_busy_o, 1);
        cyc(1);
        chk("busy_16", init_busy_o, 0);
        for (int i = 0; i < 16; i++) chk("sram_init", sram[i], 1);
        // Saturation up and down, back-to-back same-index accumulation.
        repeat (3) upd(5, 1);
        drain();
        lk(5, 3, "sat_hi");
        upd(5, 1);
        drain();
        lk(5, 3, "sat_hold");
        repeat (3) upd(0, 0);
        drain();
        lk(0, 0, "sat_lo");
        // Same-cycle lookup acceptance.
        upd(7, 1);
        drain();
        lookup_valid_i = 1;
        lookup_idx_i = 4'd7;
        #1;
        chk("lk7_rdy", lookup_ready_o, 1);
        cyc(1);
        lookup_valid_i = 0;
        chk("lk7_rv", lookup_rvalid_o, 1);
        chk("lk7_cnt", lookup_cnt_o, 2);
        // FIFO fills while lookups hold the port.
        cyc(1);
        lookup_valid_i = 1;
        lookup_idx_i = 4'd3;
        for (int i = 0; i < 4; i++) begin
            upd_valid_i = 1;
            upd_idx_i = 4'(8 + i);
            upd_taken_i = 1;
            chk("fill_rdy", upd_ready_o, 1);
            cyc(1);
        end
        upd_idx_i = 4'd13;
        chk("full_rdy", upd_ready_o, 0);
        cyc(1);
        upd_valid_i = 0;
        lookup_valid_i = 0;
        drain();
        for (int i = 8; i < 12; i++) lk(i, 2, "fill_val");
        lk(13, 1, "dropped5");
        // Lookup during UPD_WR is held off one cycle.
        upd(2, 1);
        wait_wr();
        lookup_valid_i = 1;
        lookup_idx_i = 4'd2;
        #1;
        chk("wr_lk_rdy", lookup_ready_o, 0);
        cyc(1);
        chk("wr_lk_next", lookup_ready_o, 1);
        cyc(1);
        lookup_valid_i = 0;
        chk("wr_lk_rv", lookup_rvalid_o, 1);
        chk("wr_lk_cnt", lookup_cnt_o, 2);
        // Flush in UPD_WR with two queued updates, concurrent update dropped.
        upd(12, 1);
        upd(13, 1);
        wait_wr();
        flush_bp_i = 1;
        upd_valid_i = 1;
        upd_idx_i = 4'd14;
        #1;
        chk("fl_we", mem_we_o, 0);
        chk("fl_req", mem_req_o, 0);
        chk("fl_updrdy", upd_ready_o, 0);
        cyc(1);
        flush_bp_i = 0;
        upd_valid_i = 0;
        chk("fl_busy", init_busy_o, 1);
        chk("fl_addr0", mem_addr_o, 0);
        chk("fl_we0", mem_we_o, 1);
        // Flush during INIT restarts the walk.
        cyc(5);
        flush_bp_i = 1;
        cyc(1);
        flush_bp_i = 0;
        chk("re_addr0", mem_addr_o, 0);
        cyc(16);
        chk("re_busy", init_busy_o, 0);
        lk(12, 1, "fl_val12");
        lk(13, 1, "fl_val13");
        lk(5, 1, "fl_val5");
        lk(14, 1, "fl_val14");
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
